// File: rtl/sprite_renderer.sv
// Multi-sprite frame renderer: on each frame tick it erases every sprite at its previous position, then draws each enabled one.
// Optional macro SPRITE_RENDERER_CLIP_EN suppresses pixels outside SCREEN_W x SCREEN_H; the default build wraps coordinates.
module sprite_renderer #(
    parameter int          NUM_SPR   = 4,
    parameter int          SIZE_LOG2 = 2,
    parameter int          X_W       = 8,
    parameter int          Y_W       = 7,
    parameter logic [2:0]  BG_COLOR  = 3'b000,
    parameter int          SCREEN_W  = 160,
    parameter int          SCREEN_H  = 120
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic [NUM_SPR*X_W-1:0] spr_x,
    input  logic [NUM_SPR*Y_W-1:0] spr_y,
    input  logic [NUM_SPR*3-1:0]   spr_c,
    input  logic [NUM_SPR*3-1:0]   spr_c2,
    input  logic [NUM_SPR-1:0]     spr_en,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [2:0]             vga_c,
    output logic                   vga_we,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int OFF_W  = 2 * SIZE_LOG2;
    localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPR - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ERASE, DRAW, DONE} state_t;

    state_t            state, state_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [OFF_W-1:0]  off, off_n;

    logic [X_W-1:0] old_x  [NUM_SPR];
    logic [Y_W-1:0] old_y  [NUM_SPR];
    logic           old_en [NUM_SPR];
    logic [X_W-1:0] new_x  [NUM_SPR];
    logic [Y_W-1:0] new_y  [NUM_SPR];
    logic [2:0]     new_c  [NUM_SPR];
    logic [2:0]     new_c2 [NUM_SPR];
    logic           new_en [NUM_SPR];

    logic [X_W-1:0]       cur_x;
    logic [Y_W-1:0]       cur_y;
    logic                 cur_en;
    logic [SIZE_LOG2-1:0] ox, oy;
    logic [X_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic [2:0]           pix_c;
    logic                 pix_we;
    logic                 in_range;

    // ERASE walks the previous-frame snapshot, DRAW walks the current one.
    always_comb begin
        cur_x  = (state == DRAW) ? new_x[slot]  : old_x[slot];
        cur_y  = (state == DRAW) ? new_y[slot]  : old_y[slot];
        cur_en = (state == DRAW) ? new_en[slot] : old_en[slot];
        ox     = off[SIZE_LOG2-1:0];
        oy     = off[OFF_W-1:SIZE_LOG2];
        pix_c  = BG_COLOR;
        if (state == DRAW)
            pix_c = (ox[0] ^ oy[0]) ? new_c2[slot] : new_c[slot];
    end

`ifdef SPRITE_RENDERER_CLIP_EN
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;

    // The extra carry bit makes a wrapped coordinate count as off-screen.
    always_comb begin
        sum_x    = {1'b0, cur_x} + (X_W+1)'(ox);
        sum_y    = {1'b0, cur_y} + (Y_W+1)'(oy);
        pix_x    = sum_x[X_W-1:0];
        pix_y    = sum_y[Y_W-1:0];
        in_range = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    end
`else
    always_comb begin
        pix_x    = cur_x + X_W'(ox);
        pix_y    = cur_y + Y_W'(oy);
        in_range = 1'b1;
    end
`endif

    always_comb begin
        state_n = state;
        slot_n  = slot;
        off_n   = off;
        pix_we  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick)
                    state_n = LOAD;
            end
            LOAD: begin
                state_n = ERASE;
                slot_n  = '0;
                off_n   = '0;
            end
            ERASE, DRAW: begin
                pix_we = cur_en & in_range;
                // A disabled slot costs exactly one idle cycle.
                if (!cur_en || off == '1) begin
                    off_n = '0;
                    if (slot == LAST_SLOT) begin
                        slot_n  = '0;
                        state_n = (state == ERASE) ? DRAW : DONE;
                    end else begin
                        slot_n = slot + SLOT_W'(1);
                    end
                end else begin
                    off_n = off + OFF_W'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            slot       <= '0;
            off        <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_c      <= '0;
            vga_we     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                old_x[i]  <= '0;
                old_y[i]  <= '0;
                old_en[i] <= 1'b0;
                new_x[i]  <= '0;
                new_y[i]  <= '0;
                new_c[i]  <= '0;
                new_c2[i] <= '0;
                new_en[i] <= 1'b0;
            end
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            off        <= off_n;
            vga_x      <= pix_x;
            vga_y      <= pix_y;
            vga_c      <= pix_c;
            vga_we     <= pix_we;
            busy       <= (state_n != IDLE);
            frame_done <= (state_n == DONE);
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;
            if (state == LOAD) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    old_x[i]  <= new_x[i];
                    old_y[i]  <= new_y[i];
                    old_en[i] <= new_en[i];
                    new_x[i]  <= spr_x[i*X_W +: X_W];
                    new_y[i]  <= spr_y[i*Y_W +: Y_W];
                    new_c[i]  <= spr_c[i*3 +: 3];
                    new_c2[i] <= spr_c2[i*3 +: 3];
                    new_en[i] <= spr_en[i];
                end
            end
        end
    end

endmodule
